// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: FSM state type and default gate length shared by the frequency meter
package freq_meter_pkg;
  typedef enum logic {IDLE, GATE} state_t;
  localparam int GATE_1S = 50_000_000;
endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser plus history flop giving a one-cycle rising-edge pulse
module sync_edge_detect (
  input  logic clockin,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s1, s2, hist;
  // shift the async input through two sync stages, then keep one cycle of history
  always_ff @(posedge clockin or negedge rst_n)
    if (!rst_n) {s1, s2, hist} <= '0;
    else {s1, s2, hist} <= {din, s1, s2};
  assign rise = s2 & ~hist;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter on Mhz50; optional period measurement under PERIOD_MEAS_EN
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_1S,
  parameter int GATE_W      = 26,
  parameter int CNT_W       = 16,
  parameter int PER_W       = 24
) (
  input  logic             Mhz50,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sigin,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic [PER_W-1:0] period_out,
  output logic             period_valid
);
  state_t            state;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt, next_cnt;
  logic              rise, sat, last, window_ovf;

  sync_edge_detect u_sync (
    .clockin(Mhz50),
    .rst_n  (rst_n),
    .din    (sigin),
    .rise   (rise)
  );

  assign sat      = rise & (&edge_cnt);
  assign next_cnt = sat ? edge_cnt : edge_cnt + CNT_W'(rise);
  assign last     = gate_cnt == GATE_W'(GATE_CYCLES - 1);

  // gate window FSM: count edges for GATE_CYCLES clocks, publish and restart without a dead cycle
  always_ff @(posedge Mhz50 or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      window_ovf <= 1'b0;
      freq_out   <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (state == IDLE || !enable) begin
        state      <= (state == IDLE && enable) ? GATE : IDLE;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        window_ovf <= 1'b0;
      end else if (last) begin
        freq_out   <= next_cnt;
        overflow   <= window_ovf | sat;
        freq_valid <= 1'b1;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        window_ovf <= 1'b0;
      end else begin
        gate_cnt   <= gate_cnt + GATE_W'(1);
        edge_cnt   <= next_cnt;
        window_ovf <= window_ovf | sat;
      end
    end

`ifdef PERIOD_MEAS_EN
  logic [PER_W-1:0] per_cnt;
  logic             seen;
  // cycles between consecutive edges; the first edge after enable only arms the measurement
  always_ff @(posedge Mhz50 or negedge rst_n)
    if (!rst_n) begin
      per_cnt      <= '0;
      seen         <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
    end else if (!enable) begin
      per_cnt      <= '0;
      seen         <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= rise & seen;
      per_cnt      <= rise ? '0 : per_cnt + PER_W'(~&per_cnt);
      seen         <= seen | rise;
      if (rise & seen) period_out <= (&per_cnt) ? per_cnt : per_cnt + PER_W'(1);
    end
`else
  assign period_out   = '0;
  assign period_valid = 1'b0;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of freq_meter with a 100-cycle gate, plus a 3-bit saturating copy
module tb_freq_meter;
  logic        Mhz50 = 1'b0;
  logic        rst_n, enable, sigin, sig_run;
  logic [15:0] freq_out;
  logic [2:0]  fo3;
  logic        freq_valid, overflow, fv3, ov3, pv, pv3;
  logic [23:0] period_out, po3;
  int          total = 0, bad = 0, pv_seen = 0, n, v;

  always #5 Mhz50 = ~Mhz50;

  freq_meter #(.GATE_CYCLES(100), .GATE_W(7)) u_dut (
    .Mhz50(Mhz50), .rst_n(rst_n), .enable(enable), .sigin(sigin),
    .freq_out(freq_out), .freq_valid(freq_valid), .overflow(overflow),
    .period_out(period_out), .period_valid(pv)
  );

  freq_meter #(.GATE_CYCLES(100), .GATE_W(7), .CNT_W(3)) u_sat (
    .Mhz50(Mhz50), .rst_n(rst_n), .enable(enable), .sigin(sigin),
    .freq_out(fo3), .freq_valid(fv3), .overflow(ov3),
    .period_out(po3), .period_valid(pv3)
  );

  initial begin
    int ph = 0;
    forever begin
      @(negedge Mhz50);
      #1;
      if (sig_run) begin
        ph++;
        if (ph == 5) begin
          ph = 0;
          sigin = ~sigin;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge Mhz50);
      cnt++;
      if (pv) pv_seen++;
    end while (!freq_valid && cnt < 300);
    if (!freq_valid) chk("valid_timeout", 32'(cnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sigin = 1'b0; sig_run = 1'b0;
    repeat (3) @(negedge Mhz50);
    chk("rst_freq", 32'(freq_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_valid", 32'(freq_valid), 0);
    chk("rst_period", 32'(period_out) | 32'(pv), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge Mhz50);
    // steady period-10 signal
    enable = 1'b1; sig_run = 1'b1;
    wait_valid(n);
    chk("t1_latency", 32'(n), 101);
    chk("t1_freq", 32'(freq_out), 10);
    chk("t1_ovf", 32'(overflow), 0);
    chk("t2_sat_freq", 32'(fo3), 7);
    chk("t2_sat_ovf", 32'(ov3), 1);
    chk("t2_sat_valid", 32'(fv3), 1);
    @(negedge Mhz50);
    chk("t1_pulse", 32'(freq_valid), 0);
    wait_valid(n);
    chk("t1_gap", 32'(n + 1), 100);
    chk("t1_freq2", 32'(freq_out), 10);
`ifdef PERIOD_MEAS_EN
    chk("t6_period", 32'(period_out), 10);
`else
    chk("t6_period_tied", 32'(period_out), 0);
`endif
    // quiet signal: next full window reads zero, overflow clears
    sig_run = 1'b0; sigin = 1'b0;
    wait_valid(n);
    pv_seen = 0;
    wait_valid(n);
    chk("t2_zero_freq", 32'(freq_out), 0);
    chk("t2_zero_ovf", 32'(overflow), 0);
    chk("t2_sat_zero_freq", 32'(fo3), 0);
    chk("t2_sat_zero_ovf", 32'(ov3), 0);
    chk("t6_stuck_pv", 32'(pv_seen), 0);
    // abort mid-window
    sig_run = 1'b1;
    wait_valid(n);
    wait_valid(n);
    chk("t3_pre", 32'(freq_out), 10);
    repeat (50) @(negedge Mhz50);
    enable = 1'b0;
    v = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge Mhz50);
      if (freq_valid) v++;
    end
    chk("t3_no_valid", 32'(v), 0);
    chk("t3_hold", 32'(freq_out), 10);
    enable = 1'b1;
    wait_valid(n);
    chk("t3_relatency", 32'(n), 101);
    chk("t3_refreq", 32'(freq_out), 10);
    // async reset mid-window
    repeat (30) @(negedge Mhz50);
    sig_run = 1'b0; sigin = 1'b0;
    repeat (5) @(negedge Mhz50);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_freq", 32'(freq_out), 0);
    chk("t4_sat_freq", 32'(fo3), 0);
    chk("t4_sat_ovf", 32'(ov3), 0);
    chk("t4_valid", 32'(freq_valid), 0);
    @(negedge Mhz50);
    rst_n = 1'b1; sig_run = 1'b1;
    wait_valid(n);
    chk("t4_latency", 32'(n), 101);
    chk("t4_freq_after", 32'(freq_out), 10);
    // single pulse detected on the last gate cycle
    sig_run = 1'b0; sigin = 1'b0; enable = 1'b0;
    repeat (5) @(negedge Mhz50);
    pv_seen = 0;
    enable = 1'b1;
    repeat (98) @(negedge Mhz50);
    sigin = 1'b1;
    @(negedge Mhz50);
    sigin = 1'b0;
    wait_valid(n);
    chk("t5_latency", 32'(n), 2);
    chk("t5_last_edge", 32'(freq_out), 1);
    chk("t5_ovf", 32'(overflow), 0);
    wait_valid(n);
    chk("t5_next", 32'(freq_out), 0);
    chk("t5_single_pv", 32'(pv_seen), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
